// File: rtl/pick_entry_buffer.sv
// pick_entry_buffer: gathers roulette position picks (0..7) from debounced keypad events.
// Optional macro PICK_AUTO_COMMIT_EN: the pick that completes the bet commits without KEY_OK.
module pick_entry_buffer #(
   parameter int MAX_PICKS = 4,
   parameter int KEY_BKSP  = 10,
   parameter int KEY_CLR   = 11,
   parameter int KEY_OK    = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       entry_active,
   input  logic       clear_in,
   input  logic       key_valid,
   input  logic [3:0] key_value,
   input  logic [2:0] bet_count,
   output logic [2:0] pick0,
   output logic [2:0] pick1,
   output logic [2:0] pick2,
   output logic [2:0] pick3,
   output logic [7:0] pick_mask,
   output logic [2:0] pick_cnt,
   output logic       entry_full,
   output logic       entry_done,
   output logic       key_reject,
   output logic       committed
);
   localparam logic [2:0] MAX_CNT = 3'(MAX_PICKS);
   localparam logic [3:0] K_BKSP  = 4'(KEY_BKSP);
   localparam logic [3:0] K_CLR   = 4'(KEY_CLR);
   localparam logic [3:0] K_OK    = 4'(KEY_OK);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COLLECT   = 2'd1,
      ST_FULL      = 2'd2,
      ST_COMMITTED = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic       active_q, active_d;
   logic [2:0] slot_q [4];
   logic [2:0] slot_d [4];
   logic [7:0] mask_q, mask_d;
   logic [2:0] cnt_q, cnt_d;
   logic       full_q, full_d;
   logic       done_q, done_d;
   logic       reject_q, reject_d;
   logic       committed_q, committed_d;

   logic [2:0] eff_cnt_s;
   logic       rise_s, key_live_s, at_full_s, is_digit_s;
   logic [2:0] pos_s;
   logic [1:0] top_slot_s;
   logic       acc_digit_s, acc_bksp_s, acc_clr_s, acc_ok_s, ok_quiet_s;
   logic       auto_commit_s, refuse_s;

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         active_q    <= 1'b0;
         for (int i = 0; i < 4; i++) slot_q[i] <= 3'd0;
         mask_q      <= 8'd0;
         cnt_q       <= 3'd0;
         full_q      <= 1'b0;
         done_q      <= 1'b0;
         reject_q    <= 1'b0;
         committed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         for (int i = 0; i < 4; i++) slot_q[i] <= slot_d[i];
         mask_q      <= mask_d;
         cnt_q       <= cnt_d;
         full_q      <= full_d;
         done_q      <= done_d;
         reject_q    <= reject_d;
         committed_q <= committed_d;
      end
   end

   // key decode; a key coinciding with clear_in or the entry rise is dropped silently
   always_comb begin
      if (bet_count == 3'd0) begin
         eff_cnt_s = 3'd1;
      end else if (bet_count > MAX_CNT) begin
         eff_cnt_s = MAX_CNT;
      end else begin
         eff_cnt_s = bet_count;
      end
      active_d    = entry_active;
      rise_s      = entry_active & ~active_q;
      key_live_s  = key_valid & entry_active & ~clear_in & ~rise_s &
                    ((state_q == ST_COLLECT) | (state_q == ST_FULL));
      at_full_s   = (cnt_q >= eff_cnt_s);
      is_digit_s  = (key_value >= 4'd1) && (key_value <= 4'd8);
      pos_s       = key_value[2:0] - 3'd1;
      top_slot_s  = 2'(cnt_q - 3'd1);
      acc_digit_s = key_live_s & is_digit_s & ~at_full_s & ~mask_q[pos_s];
      acc_bksp_s  = key_live_s & (key_value == K_BKSP) & (cnt_q != 3'd0);
      acc_clr_s   = key_live_s & (key_value == K_CLR);
`ifdef PICK_AUTO_COMMIT_EN
      acc_ok_s      = 1'b0;
      ok_quiet_s    = key_live_s & (key_value == K_OK);
      auto_commit_s = acc_digit_s & ((cnt_q + 3'd1) == eff_cnt_s);
`else
      acc_ok_s      = key_live_s & (key_value == K_OK) & at_full_s;
      ok_quiet_s    = 1'b0;
      auto_commit_s = 1'b0;
`endif
      refuse_s    = key_live_s & ~(acc_digit_s | acc_bksp_s | acc_clr_s | acc_ok_s | ok_quiet_s);
   end

   // pick slots, mask, count and the one-cycle pulses
   always_comb begin
      for (int i = 0; i < 4; i++) slot_d[i] = slot_q[i];
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      committed_d = committed_q;
      done_d      = 1'b0;
      reject_d    = 1'b0;
      if (clear_in || rise_s) begin
         for (int i = 0; i < 4; i++) slot_d[i] = 3'd0;
         mask_d      = 8'd0;
         cnt_d       = 3'd0;
         committed_d = 1'b0;
      end else if (acc_digit_s) begin
         slot_d[cnt_q[1:0]] = pos_s;
         mask_d[pos_s]      = 1'b1;
         cnt_d              = cnt_q + 3'd1;
         done_d             = auto_commit_s;
         committed_d        = committed_q | auto_commit_s;
      end else if (acc_bksp_s) begin
         slot_d[top_slot_s]         = 3'd0;
         mask_d[slot_q[top_slot_s]] = 1'b0;
         cnt_d                      = cnt_q - 3'd1;
      end else if (acc_clr_s) begin
         for (int i = 0; i < 4; i++) slot_d[i] = 3'd0;
         mask_d = 8'd0;
         cnt_d  = 3'd0;
      end else if (acc_ok_s) begin
         done_d      = 1'b1;
         committed_d = 1'b1;
      end else begin
         reject_d = refuse_s;
      end
      full_d = (cnt_d == eff_cnt_s);
   end

   // next state; COLLECT/FULL follow the count against the live bet so bet changes re-qualify
   always_comb begin
      state_d = state_q;
      if (clear_in) begin
         state_d = entry_active ? ST_COLLECT : ST_IDLE;
      end else if (rise_s) begin
         state_d = ST_COLLECT;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_COLLECT, ST_FULL: begin
               if (!entry_active) begin
                  state_d = ST_IDLE;
               end else if (acc_ok_s || auto_commit_s) begin
                  state_d = ST_COMMITTED;
               end else begin
                  state_d = (cnt_d >= eff_cnt_s) ? ST_FULL : ST_COLLECT;
               end
            end
            ST_COMMITTED: state_d = entry_active ? ST_COMMITTED : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign pick0      = slot_q[0];
   assign pick1      = slot_q[1];
   assign pick2      = slot_q[2];
   assign pick3      = slot_q[3];
   assign pick_mask  = mask_q;
   assign pick_cnt   = cnt_q;
   assign entry_full = full_q;
   assign entry_done = done_q;
   assign key_reject = reject_q;
   assign committed  = committed_q;
endmodule

// File: tb/tb_pick_entry_buffer.sv
// Self-checking bench for pick_entry_buffer: vector table fed through an expected-output queue.
module tb_pick_entry_buffer;
   logic       clk = 1'b0;
   logic       rst, entry_active, clear_in, key_valid;
   logic [3:0] key_value;
   logic [2:0] bet_count;
   logic [2:0] pick0, pick1, pick2, pick3;
   logic [7:0] pick_mask;
   logic [2:0] pick_cnt;
   logic       entry_full, entry_done, key_reject, committed;

   pick_entry_buffer dut (
      .clk(clk), .rst(rst), .entry_active(entry_active), .clear_in(clear_in),
      .key_valid(key_valid), .key_value(key_value), .bet_count(bet_count),
      .pick0(pick0), .pick1(pick1), .pick2(pick2), .pick3(pick3),
      .pick_mask(pick_mask), .pick_cnt(pick_cnt), .entry_full(entry_full),
      .entry_done(entry_done), .key_reject(key_reject), .committed(committed)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic [2:0] p0, p1, p2, p3;
      logic [7:0] mask;
      logic [2:0] cnt;
      logic       full, done, rej, comm;
   } out_t;

   typedef struct {
      logic       ea, clr, kv;
      logic [3:0] key;
      logic [2:0] bet;
      out_t       exp;
   } vec_t;

   vec_t vecs[$];
   out_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic out_t mk(input logic [2:0] p0, p1, p2, p3, input logic [7:0] mask,
                               input logic [2:0] cnt, input logic full, done, rej, comm);
      out_t o;
      o.p0 = p0; o.p1 = p1; o.p2 = p2; o.p3 = p3; o.mask = mask; o.cnt = cnt;
      o.full = full; o.done = done; o.rej = rej; o.comm = comm;
      return o;
   endfunction

   function automatic void add(input logic ea, clr, kv, input logic [3:0] key,
                               input logic [2:0] bet, input out_t e);
      vec_t v;
      v.ea = ea; v.clr = clr; v.kv = kv; v.key = key; v.bet = bet; v.exp = e;
      vecs.push_back(v);
   endfunction

   task automatic compare(input string name);
      out_t e, a;
      e = sb.pop_front();
      a = {pick0, pick1, pick2, pick3, pick_mask, pick_cnt, entry_full, entry_done, key_reject, committed};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got p=%0d,%0d,%0d,%0d mask=%h cnt=%0d full=%b done=%b rej=%b comm=%b; expected p=%0d,%0d,%0d,%0d mask=%h cnt=%0d full=%b done=%b rej=%b comm=%b",
                  name, a.p0, a.p1, a.p2, a.p3, a.mask, a.cnt, a.full, a.done, a.rej, a.comm,
                  e.p0, e.p1, e.p2, e.p3, e.mask, e.cnt, e.full, e.done, e.rej, e.comm);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      entry_active = v.ea; clear_in = v.clr; key_valid = v.kv; key_value = v.key; bet_count = v.bet;
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
      compare($sformatf("vec%0d", idx));
   endtask

   out_t z;
   int   done_seen;

   initial begin
      z = mk(3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PICK_AUTO_COMMIT_EN
      add(1, 0, 0, 4'd0,  3'd1, z);
      add(1, 0, 1, 4'd8,  3'd1, mk(7, 0, 0, 0, 8'h80, 1, 1, 1, 0, 1));
      add(1, 0, 1, 4'd12, 3'd1, mk(7, 0, 0, 0, 8'h80, 1, 1, 0, 0, 1));
      add(1, 0, 1, 4'd10, 3'd1, mk(7, 0, 0, 0, 8'h80, 1, 1, 0, 0, 1));
      add(0, 0, 0, 4'd0,  3'd1, mk(7, 0, 0, 0, 8'h80, 1, 1, 0, 0, 1));
      add(0, 1, 1, 4'd2,  3'd1, z);
`else
      // basic pick and commit, bet 2
      add(1, 0, 0, 4'd0,  3'd2, z);
      add(1, 0, 1, 4'd3,  3'd2, mk(2, 0, 0, 0, 8'h04, 1, 0, 0, 0, 0));
      add(1, 0, 1, 4'd7,  3'd2, mk(2, 6, 0, 0, 8'h44, 2, 1, 0, 0, 0));
      add(1, 0, 1, 4'd12, 3'd2, mk(2, 6, 0, 0, 8'h44, 2, 1, 1, 0, 1));
      add(1, 0, 0, 4'd0,  3'd2, mk(2, 6, 0, 0, 8'h44, 2, 1, 0, 0, 1));
      // duplicate rejection, bet 3
      add(0, 0, 0, 4'd0,  3'd3, mk(2, 6, 0, 0, 8'h44, 2, 0, 0, 0, 1));
      add(1, 0, 0, 4'd0,  3'd3, z);
      add(1, 0, 1, 4'd5,  3'd3, mk(4, 0, 0, 0, 8'h10, 1, 0, 0, 0, 0));
      add(1, 0, 1, 4'd5,  3'd3, mk(4, 0, 0, 0, 8'h10, 1, 0, 0, 1, 0));
      add(1, 0, 0, 4'd0,  3'd3, mk(4, 0, 0, 0, 8'h10, 1, 0, 0, 0, 0));
      // backspace then commit, bet 2
      add(1, 1, 0, 4'd0,  3'd2, z);
      add(1, 0, 1, 4'd1,  3'd2, mk(0, 0, 0, 0, 8'h01, 1, 0, 0, 0, 0));
      add(1, 0, 1, 4'd2,  3'd2, mk(0, 1, 0, 0, 8'h03, 2, 1, 0, 0, 0));
      add(1, 0, 1, 4'd10, 3'd2, mk(0, 0, 0, 0, 8'h01, 1, 0, 0, 0, 0));
      add(1, 0, 1, 4'd4,  3'd2, mk(0, 3, 0, 0, 8'h09, 2, 1, 0, 0, 0));
      add(1, 0, 1, 4'd12, 3'd2, mk(0, 3, 0, 0, 8'h09, 2, 1, 1, 0, 1));
      // early OK, clear, key 9, backspace at zero, bet 4
      add(0, 0, 0, 4'd0,  3'd4, mk(0, 3, 0, 0, 8'h09, 2, 0, 0, 0, 1));
      add(1, 0, 0, 4'd0,  3'd4, z);
      add(1, 0, 1, 4'd1,  3'd4, mk(0, 0, 0, 0, 8'h01, 1, 0, 0, 0, 0));
      add(1, 0, 1, 4'd12, 3'd4, mk(0, 0, 0, 0, 8'h01, 1, 0, 0, 1, 0));
      add(1, 0, 1, 4'd11, 3'd4, z);
      add(1, 0, 1, 4'd9,  3'd4, mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0));
      add(1, 0, 1, 4'd10, 3'd4, mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0));
      // bet count changes mid-entry, bet 0 treated as 1
      add(1, 0, 1, 4'd2,  3'd1, mk(1, 0, 0, 0, 8'h02, 1, 1, 0, 0, 0));
      add(1, 0, 1, 4'd3,  3'd1, mk(1, 0, 0, 0, 8'h02, 1, 1, 0, 1, 0));
      add(1, 0, 0, 4'd0,  3'd3, mk(1, 0, 0, 0, 8'h02, 1, 0, 0, 0, 0));
      add(1, 0, 1, 4'd3,  3'd3, mk(1, 2, 0, 0, 8'h06, 2, 0, 0, 0, 0));
      add(1, 0, 0, 4'd0,  3'd1, mk(1, 2, 0, 0, 8'h06, 2, 0, 0, 0, 0));
      add(1, 0, 1, 4'd4,  3'd1, mk(1, 2, 0, 0, 8'h06, 2, 0, 0, 1, 0));
      add(1, 0, 1, 4'd10, 3'd1, mk(1, 0, 0, 0, 8'h02, 1, 1, 0, 0, 0));
      add(1, 0, 1, 4'd12, 3'd0, mk(1, 0, 0, 0, 8'h02, 1, 1, 1, 0, 1));
      // drop entry, clear with a coincident key
      add(0, 0, 0, 4'd0,  3'd0, mk(1, 0, 0, 0, 8'h02, 1, 1, 0, 0, 1));
      add(0, 1, 1, 4'd2,  3'd0, z);
      add(0, 0, 1, 4'd3,  3'd0, z);
      // bet above MAX_PICKS clamps to 4, fill every slot
      add(1, 0, 0, 4'd0,  3'd7, z);
      add(1, 0, 1, 4'd8,  3'd7, mk(7, 0, 0, 0, 8'h80, 1, 0, 0, 0, 0));
      add(1, 0, 1, 4'd7,  3'd7, mk(7, 6, 0, 0, 8'hC0, 2, 0, 0, 0, 0));
      add(1, 0, 1, 4'd6,  3'd7, mk(7, 6, 5, 0, 8'hE0, 3, 0, 0, 0, 0));
      add(1, 0, 1, 4'd5,  3'd7, mk(7, 6, 5, 4, 8'hF0, 4, 1, 0, 0, 0));
      add(1, 0, 1, 4'd12, 3'd7, mk(7, 6, 5, 4, 8'hF0, 4, 1, 1, 0, 1));
      add(1, 0, 1, 4'd1,  3'd7, mk(7, 6, 5, 4, 8'hF0, 4, 1, 0, 0, 1));
      // key on the entry rise is dropped
      add(0, 0, 0, 4'd0,  3'd7, mk(7, 6, 5, 4, 8'hF0, 4, 1, 0, 0, 1));
      add(1, 0, 1, 4'd1,  3'd7, z);
      add(1, 0, 0, 4'd0,  3'd7, z);
`endif

      // reset with live inputs
      rst = 1'b0; entry_active = 1'b1; clear_in = 1'b0; key_valid = 1'b1; key_value = 4'd3; bet_count = 3'd2;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(z);
         @(posedge clk);
         #1;
         compare("reset");
      end
      @(negedge clk);
      rst = 1'b1; entry_active = 1'b0; key_valid = 1'b0;
      sb.push_back(z);
      @(posedge clk);
      #1;
      compare("post_reset_idle");

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // entry_done must pulse exactly once within a bounded window
      @(negedge clk);
      entry_active = 1'b0; clear_in = 1'b0; key_valid = 1'b0; bet_count = 3'd1;
      @(negedge clk);
      entry_active = 1'b1;
      @(negedge clk);
      key_valid = 1'b1; key_value = 4'd3;
`ifndef PICK_AUTO_COMMIT_EN
      @(negedge clk);
      key_value = 4'd12;
`endif
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         key_valid = 1'b0;
         if (entry_done) done_seen++;
      end
      checks++;
      if (done_seen != 1) begin
         errors++;
         $display("FAIL done_pulse: got %0d pulses, expected 1", done_seen);
      end
      sb.push_back(mk(2, 0, 0, 0, 8'h04, 1, 1, 0, 0, 1));
      compare("after_commit_hold");

      // mid-run reset clears everything
      @(negedge clk);
      rst = 1'b0;
      sb.push_back(z);
      @(posedge clk);
      #1;
      compare("midrun_reset");
      rst = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pick_entry_buffer.md
Name: pick_entry_buffer

Overview:
- Collects the player's roulette position picks from debounced keypad events during the number-input phase.
- Rejects duplicates, supports backspace, clear and commit, and enforces the pick count fixed by the bet selection.
- Sits between the keypad decoder and the hit checker / LCD formatter.
- Presents zero-based positions (0..7) directly comparable with the wheel's result position.

Parameters:
MAX_PICKS, 4, maximum picks held; fixes slot count and pick_cnt range
KEY_BKSP, 10, key_value code for backspace ('*')
KEY_CLR, 11, key_value code for clear-all ('#')
KEY_OK, 12, key_value code for commit

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  reset, synchronous, active-low
entry_active  input  1  high while the game controller is in the number-input state
clear_in  input  1  round reset / clear request, one-cycle pulse
key_valid  input  1  one-cycle strobe, key_value valid
key_value  input  4  key code 1..12
bet_count  input  3  required picks, 1..MAX_PICKS
pick0..pick3  output  3 each  stored positions, zero-based
pick_mask  output  8  one-hot OR of all stored positions
pick_cnt  output  3  number of valid picks, 0..MAX_PICKS
entry_full  output  1  high when pick_cnt == effective bet_count
entry_done  output  1  one-cycle pulse on successful commit
key_reject  output  1  one-cycle pulse when a key is refused
committed  output  1  level, picks frozen after commit

Behaviour:
- Reset (rst==0 at a clk edge): all outputs 0, state IDLE.
- Effective count: bet_count 0 is treated as 1; values above MAX_PICKS are treated as MAX_PICKS.
- State machine:
  - IDLE -> COLLECT on the rising edge of entry_active (registered compare). On entry, all picks, pick_mask and pick_cnt are cleared.
  - COLLECT -> FULL when pick_cnt reaches the effective count.
  - FULL -> COLLECT on backspace.
  - FULL -> COMMITTED on KEY_OK: entry_done pulses for 1 cycle and committed is set.
  - COMMITTED -> IDLE when entry_active falls. Picks and committed are held until the next entry_active rise or clear_in.
  - Any state -> IDLE when entry_active is low, except COMMITTED, which holds its picks.
- Keys are accepted only in COLLECT/FULL with key_valid high. Outputs update on the cycle after the strobe (1-cycle latency).
  - Digit 1..8 in COLLECT:
    - Position p = key-1.
    - If pick_mask[p] is already set, reject.
    - Otherwise store p in slot pick_cnt, set pick_mask[p] and increment pick_cnt.
  - Digit 1..8 in FULL: reject, no change.
  - KEY_BKSP: clears the top slot, its mask bit and decrements pick_cnt. Reject if pick_cnt==0.
  - KEY_CLR: clears all slots and returns to COLLECT.
  - KEY_OK: reject if not FULL.
  - Key 9, or any key outside 1..12: reject.
- Keys in IDLE/COMMITTED are ignored silently (no reject pulse).
- Cleared slots read 0. Consumers use pick_cnt to qualify slots.
- Priority within a cycle: rst > clear_in > entry_active rising edge > key event. A key arriving in the same cycle as clear_in or the entry_active rise is dropped without a reject pulse.
- clear_in in any state: clear all, state becomes COLLECT if entry_active is high, otherwise IDLE. committed falls.
- bet_count changing mid-entry: entry_full is recomputed. If pick_cnt exceeds the new effective count, state is FULL and digits are rejected until backspaced below the count.
- entry_done and key_reject are never asserted in the same cycle.

Optional Feature:
- Macro: PICK_AUTO_COMMIT_EN.
- Defined: the accepted digit that makes pick_cnt reach the effective count moves the state directly to COMMITTED and pulses entry_done on the following cycle. KEY_OK is then ignored (no reject). Backspace after auto-commit has no effect.
- Undefined: explicit KEY_OK is required, as described in Behaviour.

Test Plan:
- Reset, then raise entry_active with bet_count=2; press 3, 7, 12 -> pick0=2, pick1=6, pick_mask=8'h44, pick_cnt=2, entry_full=1, entry_done pulses one cycle after the 12 strobe, committed=1.
- bet_count=3; press 5, 5 -> second press gives key_reject pulse, pick_cnt stays 1, pick_mask=8'h10.
- bet_count=2; press 1, 2, 10, 4, 12 -> after backspace pick_cnt=1, then pick1=3, pick_mask=8'h09, commit succeeds.
- bet_count=4; press 1, 12 -> key_reject on 12; press 11 -> pick_cnt=0, pick_mask=0; press 9 -> key_reject, no state change.
- After commit, drop entry_active, pulse clear_in with a simultaneous key_valid (key 2) -> all outputs cleared, no pick stored, no key_reject.
- PICK_AUTO_COMMIT_EN defined, bet_count=1; press 8 -> pick0=7, entry_done pulses without KEY_OK; a later 12 gives no reject.
